// File: rtl/wb_burst_ram.sv
// rtl/wb_burst_ram.sv - Wishbone B4 slave RAM with wait states, registered-feedback bursts and ERR
// One FSM owns ack/err/dat_o; the array itself is written on the edge that closes an acked beat.
module wb_burst_ram #(
    parameter int    DW          = 32,
    parameter int    DEPTH       = 8192,
    parameter int    AW          = 32,
    parameter int    WAIT_STATES = 0,
    parameter string MEMFILE     = ""
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o,
    output logic [DW-1:0]   wb_dat_o
);

    localparam int SW   = DW / 8;
    localparam int OFFW = (SW > 1) ? $clog2(SW) : 0;
    localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);
    // Contents power up undefined; the init-file name is kept for drop-in compatibility.
    localparam string unused_memfile = MEMFILE;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          ack_q;
    logic          err_q;
    logic [DW-1:0] dat_q;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [AW-1:0] idx_inc;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] nxt_idx;
    logic          req;
    logic          cur_ok;
    logic          nxt_ok;
    logic          cti_incr;
    logic          first_go;
    logic          we_commit;

    assign idx      = wb_adr_i >> OFFW;
    assign idx_inc  = idx + AW'(1);
    assign req      = wb_cyc_i & wb_stb_i;
    assign cti_incr = (wb_cti_i == 3'b010);

    // Linear bursts use an all-ones mask so the whole index increments.
    always_comb begin
        wrap_mask = '1;
        case (wb_bte_i)
            2'b01:   wrap_mask = AW'(3);
            2'b10:   wrap_mask = AW'(7);
            2'b11:   wrap_mask = AW'(15);
            default: wrap_mask = '1;
        endcase
    end

    assign nxt_idx = (idx & ~wrap_mask) | (idx_inc & wrap_mask);
    assign cur_ok  = ({1'b0, idx} < DEPTH_W);
    assign nxt_ok  = ({1'b0, nxt_idx} < DEPTH_W);

    assign first_go = req & (((state_q == S_IDLE) & ~ack_q & ~err_q & (WAIT_STATES == 0)) |
                             ((state_q == S_WAIT) & (cnt_q == 4'd1)));

    assign we_commit = ack_q & req & wb_we_i & cur_ok;

    always_ff @(posedge wb_clk_i) begin
        if (we_commit) begin
            for (int i = 0; i < SW; i++) begin
                if (wb_sel_i[i]) begin
                    mem[idx[MW-1:0]][i*8 +: 8] <= wb_dat_i[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req && !ack_q && !err_q && WAIT_STATES != 0) begin
                        state_q <= S_WAIT;
                        cnt_q   <= WS;
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_BURST: begin
                    // Each acked beat with cti=010 prefetches the next word; anything else ends it.
                    if (!req || !cti_incr) begin
                        state_q <= S_IDLE;
                    end else if (nxt_ok) begin
                        ack_q <= 1'b1;
                        dat_q <= mem[nxt_idx[MW-1:0]];
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (first_go) begin
                cnt_q <= 4'd0;
                if (cur_ok) begin
                    ack_q   <= 1'b1;
                    dat_q   <= mem[idx[MW-1:0]];
                    state_q <= cti_incr ? S_BURST : S_IDLE;
                end else begin
                    err_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_burst_ram.sv
// tb/tb_wb_burst_ram.sv - directed and randomized bench for wb_burst_ram against a word-array model
module tb_wb_burst_ram;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        cyc0, stb0, cyc1, stb1;
    logic        ack0, err0, rty0, ack1, err1, rty1;
    logic [31:0] dat0, dat1;

    logic [31:0] ref_mem [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    wb_burst_ram #(.DW(32), .DEPTH(DEPTH), .AW(32), .WAIT_STATES(0), .MEMFILE("")) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte), .wb_cyc_i(cyc0), .wb_stb_i(stb0),
        .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0), .wb_dat_o(dat0)
    );

    wb_burst_ram #(.DW(32), .DEPTH(DEPTH), .AW(32), .WAIT_STATES(3), .MEMFILE("")) u_dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cti_i(cti), .wb_bte_i(bte), .wb_cyc_i(cyc1), .wb_stb_i(stb1),
        .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1), .wb_dat_o(dat1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input int i, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[i][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic int next_word(input int i, input logic [1:0] b);
        int n;
        case (b)
            2'b00:   return i + 1;
            2'b01:   n = 4;
            2'b10:   n = 8;
            default: n = 16;
        endcase
        return (i / n) * n + ((i % n) + 1) % n;
    endfunction

    task automatic idle_bus();
        cyc0 = 1'b0; stb0 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
        we = 1'b0; cti = 3'b000; bte = 2'b00; sel = 4'h0;
    endtask

    task automatic classic(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output logic got_ack,
                           output logic got_err, output logic [31:0] rdata);
        adr = a; dat_i = d; sel = s; we = w; cti = 3'b000; bte = 2'b00;
        if (u == 0) begin cyc0 = 1'b1; stb0 = 1'b1; end
        else begin cyc1 = 1'b1; stb1 = 1'b1; end
        lat = 0;
        while (lat < 40 && !((u == 0) ? (ack0 | err0) : (ack1 | err1))) begin
            @(posedge clk); #1; lat++;
        end
        got_ack = (u == 0) ? ack0 : ack1;
        got_err = (u == 0) ? err0 : err1;
        rdata   = (u == 0) ? dat0 : dat1;
        @(posedge clk); #1;
        idle_bus();
        chk("term_pulse", (u == 0) ? {ack0, err0} : {ack1, err1}, 32'd0);
    endtask

    task automatic wr0(input int i, input logic [31:0] d, input logic [3:0] s);
        int lat; logic a, e; logic [31:0] r; bit oor;
        oor = (i >= DEPTH);
        classic(0, 1'b1, (32'(i) << 2) | 32'($urandom_range(0, 3)), d, s, lat, a, e, r);
        chk("wr_lat", lat, 32'd1);
        chk("wr_ack", a, !oor);
        chk("wr_err", e, oor);
        if (!oor) model_write(i, d, s);
    endtask

    task automatic rd0(input int i, output logic [31:0] r);
        int lat; logic a, e; bit oor;
        oor = (i >= DEPTH);
        classic(0, 1'b0, 32'(i) << 2, 32'd0, 4'($urandom), lat, a, e, r);
        chk("rd_lat", lat, 32'd1);
        chk("rd_ack", a, !oor);
        chk("rd_err", e, oor);
        if (!oor) chk("rd_data", r, ref_mem[i]);
    endtask

    task automatic burst(input bit w, input int start, input logic [1:0] b, input int nb,
                         input int abort_after);
        int i, lat; bit oor; logic [31:0] d; logic [3:0] s;
        i = start;
        for (int k = 0; k < nb; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                i = next_word(i, b);
            end
            d = $urandom; s = 4'($urandom);
            adr = 32'(i) << 2; dat_i = d; sel = s; we = w; bte = b;
            cti = (k == nb - 1) ? 3'b111 : 3'b010;
            if (k == 0) begin
                cyc0 = 1'b1; stb0 = 1'b1; lat = 0;
                while (lat < 40 && !(ack0 | err0)) begin
                    @(posedge clk); #1; lat++;
                end
                chk("bst_lat", lat, 32'd1);
            end
            oor = (i >= DEPTH);
            chk("bst_ack", ack0, !oor);
            chk("bst_err", err0, oor);
            if (oor) break;
            if (w) model_write(i, d, s);
            else   chk("bst_dat", dat0, ref_mem[i]);
            if (k + 1 == abort_after) begin
                @(posedge clk); #1;
                idle_bus();
                @(posedge clk); #1;
                chk("abort_ack", {ack0, err0}, 32'd0);
                return;
            end
        end
        @(posedge clk); #1;
        idle_bus();
        chk("bst_end", {ack0, err0}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int lat, nb;
        logic a, e;

        rst = 1'b1; adr = '0; dat_i = '0;
        idle_bus();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack0", ack0, 32'd0);
        chk("rst_err0", err0, 32'd0);
        chk("rst_dat0", dat0, 32'd0);
        chk("rst_ack3", ack1, 32'd0);
        chk("rst_dat3", dat1, 32'd0);
        chk("rty_tied", {rty0, rty1}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        wr0(4, 32'hDEADBEEF, 4'hF);
        wr0(4, 32'h000000AA, 4'h1);
        rd0(4, r);
        chk("merge_bytes", r, 32'hDEADBEAA);

        classic(1, 1'b1, 32'h0, 32'h13579BDF, 4'hF, lat, a, e, r);
        chk("ws3_wr_lat", lat, 32'd4);
        chk("ws3_wr_ack", a, 32'd1);
        classic(1, 1'b0, 32'h0, 32'h0, 4'hF, lat, a, e, r);
        chk("ws3_rd_lat", lat, 32'd4);
        chk("ws3_rd_ack", {a, e}, 32'd2);
        chk("ws3_rd_dat", r, 32'h13579BDF);

        for (int i = 0; i < 64; i++) wr0(i, $urandom, 4'hF);
        for (int i = 4; i < 8; i++) wr0(i, 32'(i), 4'hF);
        wr0(DEPTH - 1, $urandom, 4'hF);

        burst(1'b0, 6, 2'b01, 4, 0);

        wr0(DEPTH, 32'hBAD0BAD0, 4'hF);
        rd0(0, r);
        burst(1'b0, DEPTH - 1, 2'b00, 4, 0);
        rd0(5, r);

        burst(1'b1, 0, 2'b00, 8, 3);
        for (int i = 0; i < 8; i++) rd0(i, r);

        for (int t = 0; t < 30; t++) begin
            int i;
            i = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 100))
                                            : int'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) wr0(i, $urandom, 4'($urandom));
            else rd0(i, r);
        end

        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0:       nb = 1;
                1:       nb = 4;
                2:       nb = 8;
                default: nb = 16;
            endcase
            burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 47)),
                  2'($urandom_range(0, 3)), nb, 0);
        end
        for (int i = 0; i < 64; i++) rd0(i, r);

        adr = 32'd8 << 2; we = 1'b0; cti = 3'b010; bte = 2'b00; sel = 4'hF;
        cyc0 = 1'b1; stb0 = 1'b1; lat = 0;
        while (lat < 40 && !ack0) begin
            @(posedge clk); #1; lat++;
        end
        chk("rb_beat0", dat0, ref_mem[8]);
        @(posedge clk); #1;
        adr = 32'd9 << 2;
        chk("rb_beat1", ack0, 32'd1);
        @(posedge clk); #1;
        adr = 32'd10 << 2;
        chk("rb_beat2", ack0, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("rb_async_ack", ack0, 32'd0);
        chk("rb_async_err", err0, 32'd0);
        chk("rb_async_dat", dat0, 32'd0);
        idle_bus();
        @(posedge clk); #1;
        rst = 1'b0;
        rd0(3, r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
